// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and defaults for the SPI shifter slice
// Contents: DATA_W_DEF (default transfer width), spi_state_t (shifter FSM
// states), mode_sel() (picks the strobe pair for the latched clock mode).
package spi_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } spi_state_t;

  // Modes 0 and 3 share the sclk0 strobe pair, modes 1 and 2 the sclk pair.
  function automatic logic mode_sel(input logic cpol, input logic cpha);
    return cpol ^ cpha;
  endfunction

endpackage

// File: rtl/spi_shifter_if.sv
// rtl/spi_shifter_if.sv - bus bundle between the SPI shifter and its controller
// master: drives ss_i, send_data_i, data_mosi_i, mode bits, baud strobes, miso_i
// slave : drives mosi_o, data_miso_o, receive_data_o, busy_o
interface spi_shifter_if import spi_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);
  logic              ss_i;
  logic              send_data_i;
  logic [DATA_W-1:0] data_mosi_i;
  logic              lsbfe_i;
  logic              cpol_i;
  logic              cpha_i;
  logic              mosi_send_sclk_i;
  logic              mosi_send_sclk0_i;
  logic              miso_recieve_sclk_i;
  logic              miso_recieve_sclk0_i;
  logic              miso_i;
  logic              mosi_o;
  logic [DATA_W-1:0] data_miso_o;
  logic              receive_data_o;
  logic              busy_o;

  modport master (
    output ss_i, send_data_i, data_mosi_i, lsbfe_i, cpol_i, cpha_i,
           mosi_send_sclk_i, mosi_send_sclk0_i,
           miso_recieve_sclk_i, miso_recieve_sclk0_i, miso_i,
    input  mosi_o, data_miso_o, receive_data_o, busy_o
  );

  modport slave (
    input  ss_i, send_data_i, data_mosi_i, lsbfe_i, cpol_i, cpha_i,
           mosi_send_sclk_i, mosi_send_sclk0_i,
           miso_recieve_sclk_i, miso_recieve_sclk0_i, miso_i,
    output mosi_o, data_miso_o, receive_data_o, busy_o
  );

endinterface

// File: rtl/spi_bit_counter.sv
// rtl/spi_bit_counter.sv - up/down bit index with load and terminal flags
// Ports: PCLK, PRESET (async, active-high), clr_i (zero index), load_i (start
// at 0 counting up or DATA_W-1 counting down per up_i), step_i (advance),
// idx_o (current bit index), last_o (next step is the DATA_W-th),
// done_o (all DATA_W steps taken; further steps are ignored).
module spi_bit_counter import spi_pkg::*; #(
  parameter int  DATA_W = DATA_W_DEF,
  localparam int IDX_W  = $clog2(DATA_W),
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             up_i,
  input  logic             step_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o,
  output logic             done_o
);

  logic             up_q;
  logic [CNT_W-1:0] cnt_q;

  assign last_o = (cnt_q == CNT_W'(DATA_W - 1));
  assign done_o = (cnt_q == CNT_W'(DATA_W));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      idx_o <= '0;
      cnt_q <= '0;
      up_q  <= 1'b1;
    end else if (clr_i) begin
      idx_o <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      idx_o <= up_i ? '0 : IDX_W'(DATA_W - 1);
      cnt_q <= '0;
      up_q  <= up_i;
    end else if (step_i && !done_o) begin
      idx_o <= up_q ? idx_o + IDX_W'(1) : idx_o - IDX_W'(1);
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_shifter.sv
// rtl/spi_shifter.sv - SPI serialiser/deserialiser driven by baud strobes
// Ports: PCLK, PRESET (async, active-high), bus (spi_shifter_if.slave):
// load a word with send_data_i, shift it out on mosi_o and assemble miso_i
// into data_miso_o while ss_i is low; receive_data_o pulses per full word.
module spi_shifter import spi_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic         PCLK,
  input  logic         PRESET,
  spi_shifter_if.slave bus
);

  localparam int IDX_W = $clog2(DATA_W);

  spi_state_t        state;
  logic [DATA_W-1:0] tx_reg;
  logic [DATA_W-1:0] rx_reg;
  logic [DATA_W-1:0] rx_next;
  logic              sel_q;
  logic [IDX_W-1:0]  tx_idx;
  logic [IDX_W-1:0]  rx_idx;
  logic              tx_last_unused;
  logic              tx_done;
  logic              rx_last;
  logic              rx_done;

  // Strobes only count inside a live transfer; ss_i high in ACTIVE is an abort.
  logic live;
  logic start;
  logic abort;
  logic send_stb;
  logic samp_stb;
  logic tx_fire;
  logic rx_fire;
  logic rx_finish;

  assign live      = (state == ACTIVE) && !bus.ss_i;
  assign start     = (state == LOADED) && !bus.ss_i;
  assign abort     = (state == ACTIVE) && bus.ss_i;
  assign send_stb  = sel_q ? bus.mosi_send_sclk_i   : bus.mosi_send_sclk0_i;
  assign samp_stb  = sel_q ? bus.miso_recieve_sclk_i : bus.miso_recieve_sclk0_i;
  assign tx_fire   = live && send_stb && !tx_done;
  assign rx_fire   = live && samp_stb && !rx_done;
  assign rx_finish = rx_fire && rx_last;

  // Word as it stands once the current sample lands, so the final bit is
  // included when data_miso_o is loaded.
  always_comb begin
    rx_next         = rx_reg;
    rx_next[rx_idx] = bus.miso_i;
  end

  spi_bit_counter #(.DATA_W(DATA_W)) u_tx_cnt (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .clr_i  (abort),
    .load_i (start),
    .up_i   (bus.lsbfe_i),
    .step_i (tx_fire),
    .idx_o  (tx_idx),
    .last_o (tx_last_unused),
    .done_o (tx_done)
  );

  spi_bit_counter #(.DATA_W(DATA_W)) u_rx_cnt (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .clr_i  (abort),
    .load_i (start),
    .up_i   (bus.lsbfe_i),
    .step_i (rx_fire),
    .idx_o  (rx_idx),
    .last_o (rx_last),
    .done_o (rx_done)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state              <= IDLE;
      tx_reg             <= '0;
      rx_reg             <= '0;
      sel_q              <= 1'b0;
      bus.mosi_o         <= 1'b0;
      bus.data_miso_o    <= '0;
      bus.receive_data_o <= 1'b0;
      bus.busy_o         <= 1'b0;
    end else begin
      bus.receive_data_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.send_data_i) begin
            tx_reg     <= bus.data_mosi_i;
            state      <= LOADED;
            bus.busy_o <= 1'b1;
          end
        end
        LOADED: begin
          if (start) begin
            sel_q <= mode_sel(bus.cpol_i, bus.cpha_i);
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (abort) begin
            state      <= IDLE;
            bus.busy_o <= 1'b0;
          end else begin
            if (tx_fire) begin
              bus.mosi_o <= tx_reg[tx_idx];
            end
            if (rx_fire) begin
              rx_reg <= rx_next;
            end
            if (rx_finish) begin
              bus.data_miso_o    <= rx_next;
              bus.receive_data_o <= 1'b1;
              bus.busy_o         <= 1'b0;
              state              <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shifter.sv
// tb/tb_spi_shifter.sv - directed, table-driven bench for spi_shifter
module tb_spi_shifter;
  import spi_pkg::*;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;

  always #5 PCLK = ~PCLK;

  spi_shifter_if #(.DATA_W(8)) bus ();

  spi_shifter #(.DATA_W(8)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [7:0] data;
    logic       lsbfe;
    logic       cpol;
    logic       cpha;
    logic       sim;
    logic [7:0] miso_seq;
    logic [7:0] exp_mosi_seq;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[4];

  int checks    = 0;
  int errors    = 0;
  int pulse_cnt = 0;

  always @(negedge PCLK) begin
    if (bus.receive_data_o === 1'b1) pulse_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_strobes(input logic sel, input logic send, input logic samp);
    bus.mosi_send_sclk_i     = sel ? send : 1'b0;
    bus.miso_recieve_sclk_i  = sel ? samp : 1'b0;
    bus.mosi_send_sclk0_i    = sel ? 1'b0 : send;
    bus.miso_recieve_sclk0_i = sel ? 1'b0 : samp;
  endtask

  task automatic load_xfer(input logic [7:0] data, input logic lsbfe,
                           input logic cpol, input logic cpha);
    bus.data_mosi_i = data;
    bus.lsbfe_i     = lsbfe;
    bus.cpol_i      = cpol;
    bus.cpha_i      = cpha;
    bus.send_data_i = 1'b1;
    @(negedge PCLK);
    bus.send_data_i = 1'b0;
  endtask

  task automatic go_active();
    bus.ss_i = 1'b0;
    @(negedge PCLK);
  endtask

  // Separate mode: a distractor cycle on the unselected pair, then send, then
  // sample. Simultaneous mode: both selected strobes in one cycle.
  task automatic do_bit(input logic sel, input logic sim, input logic miso_b,
                        output logic mosi_b, output logic rcv);
    if (!sim) begin
      set_strobes(!sel, 1'b1, 1'b1);
      @(negedge PCLK);
      set_strobes(sel, 1'b1, 1'b0);
      @(negedge PCLK);
      mosi_b = bus.mosi_o;
      set_strobes(sel, 1'b0, 1'b1);
      bus.miso_i = miso_b;
      @(negedge PCLK);
      rcv = bus.receive_data_o;
      set_strobes(sel, 1'b0, 1'b0);
    end else begin
      set_strobes(sel, 1'b1, 1'b1);
      bus.miso_i = miso_b;
      @(negedge PCLK);
      mosi_b = bus.mosi_o;
      rcv    = bus.receive_data_o;
      set_strobes(sel, 1'b0, 1'b0);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] got;
    logic       early;
    logic       last_r;
    logic       r;
    logic       m;
    logic       sel;
    sel       = v.cpol ^ v.cpha;
    early     = 1'b0;
    last_r    = 1'b0;
    got       = '0;
    pulse_cnt = 0;
    load_xfer(v.data, v.lsbfe, v.cpol, v.cpha);
    chk({tag, "_busy_loaded"}, 32'(bus.busy_o), 32'd1);
    go_active();
    // Mode inputs flip mid-transfer and must not matter.
    bus.lsbfe_i = ~v.lsbfe;
    bus.cpol_i  = ~v.cpol;
    for (int b = 0; b < 8; b++) begin
      do_bit(sel, v.sim, v.miso_seq[7-b], m, r);
      got[7-b] = m;
      if (b < 7) early = early | r;
      else       last_r = r;
    end
    chk({tag, "_mosi_seq"}, 32'(got), 32'(v.exp_mosi_seq));
    chk({tag, "_rcv_early"}, 32'(early), 32'd0);
    chk({tag, "_rcv_at_last"}, 32'(last_r), 32'd1);
    chk({tag, "_data_miso"}, 32'(bus.data_miso_o), 32'(v.exp_miso));
    @(negedge PCLK);
    chk({tag, "_busy_done"}, 32'(bus.busy_o), 32'd0);
    @(negedge PCLK);
    chk({tag, "_state_idle"}, 32'(dut.state), 32'(IDLE));
    chk({tag, "_pulses"}, 32'(pulse_cnt), 32'd1);
    bus.ss_i = 1'b1;
  endtask

  initial begin
    logic       m;
    logic       r;
    logic [3:0] got4;
    logic [7:0] got8;
    logic       mosi_before;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h1E, 8'h80, 8'h78};
    vecs[2] = '{8'hC1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h96, 8'h83, 8'h69};
    vecs[3] = '{8'h7E, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 8'h7E, 8'h3C};

    bus.ss_i        = 1'b1;
    bus.send_data_i = 1'b0;
    bus.data_mosi_i = '0;
    bus.lsbfe_i     = 1'b0;
    bus.cpol_i      = 1'b0;
    bus.cpha_i      = 1'b0;
    bus.miso_i      = 1'b0;
    set_strobes(1'b0, 1'b0, 1'b0);

    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_mosi", 32'(bus.mosi_o), 32'd0);
    chk("rst_data_miso", 32'(bus.data_miso_o), 32'd0);
    chk("rst_rcv", 32'(bus.receive_data_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    PRESET = 1'b0;
    @(negedge PCLK);

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      @(negedge PCLK);
    end

    // Abort: ss_i rises after four samples.
    pulse_cnt = 0;
    load_xfer(8'h55, 1'b0, 1'b0, 1'b0);
    go_active();
    got4 = '0;
    for (int b = 0; b < 4; b++) begin
      do_bit(1'b0, 1'b0, 1'b1, m, r);
      got4[3-b] = m;
    end
    chk("abort_mosi4", 32'(got4), 32'h5);
    bus.ss_i = 1'b1;
    @(negedge PCLK);
    chk("abort_state", 32'(dut.state), 32'(IDLE));
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    chk("abort_data_miso", 32'(bus.data_miso_o), 32'h3C);
    chk("abort_tx_idx", 32'(dut.tx_idx), 32'd0);
    chk("abort_rx_idx", 32'(dut.rx_idx), 32'd0);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("abort_pulses", 32'(pulse_cnt), 32'd0);

    // Strobes while ss_i is high, then send_data_i during ACTIVE.
    pulse_cnt = 0;
    load_xfer(8'h96, 1'b0, 1'b0, 1'b0);
    mosi_before = bus.mosi_o;
    bus.mosi_send_sclk_i     = 1'b1;
    bus.mosi_send_sclk0_i    = 1'b1;
    bus.miso_recieve_sclk_i  = 1'b1;
    bus.miso_recieve_sclk0_i = 1'b1;
    repeat (3) @(negedge PCLK);
    set_strobes(1'b0, 1'b0, 1'b0);
    chk("ssh_state", 32'(dut.state), 32'(LOADED));
    chk("ssh_tx_idx", 32'(dut.tx_idx), 32'd0);
    chk("ssh_rx_idx", 32'(dut.rx_idx), 32'd0);
    chk("ssh_mosi", 32'(bus.mosi_o), 32'(mosi_before));
    chk("ssh_tx_reg", 32'(dut.tx_reg), 32'h96);
    go_active();
    got8 = '0;
    for (int b = 0; b < 2; b++) begin
      do_bit(1'b0, 1'b0, 1'b1, m, r);
      got8[7-b] = m;
    end
    bus.data_mosi_i = 8'h11;
    bus.send_data_i = 1'b1;
    @(negedge PCLK);
    bus.send_data_i = 1'b0;
    chk("act_send_tx_reg", 32'(dut.tx_reg), 32'h96);
    chk("act_send_state", 32'(dut.state), 32'(ACTIVE));
    chk("act_send_tx_idx", 32'(dut.tx_idx), 32'd5);
    chk("act_send_rx_idx", 32'(dut.rx_idx), 32'd5);
    for (int b = 2; b < 8; b++) begin
      do_bit(1'b0, 1'b0, 1'b1, m, r);
      got8[7-b] = m;
    end
    chk("act_send_mosi_seq", 32'(got8), 32'h96);
    chk("act_send_data_miso", 32'(bus.data_miso_o), 32'hFF);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("act_send_pulses", 32'(pulse_cnt), 32'd1);
    bus.ss_i = 1'b1;
    @(negedge PCLK);

    // Reset mid-transfer after five bits.
    load_xfer(8'hFF, 1'b0, 1'b0, 1'b0);
    go_active();
    for (int b = 0; b < 5; b++) begin
      do_bit(1'b0, 1'b0, 1'b0, m, r);
    end
    chk("prerst_mosi", 32'(bus.mosi_o), 32'd1);
    PRESET = 1'b1;
    #1;
    chk("midrst_mosi", 32'(bus.mosi_o), 32'd0);
    chk("midrst_data_miso", 32'(bus.data_miso_o), 32'd0);
    chk("midrst_rcv", 32'(bus.receive_data_o), 32'd0);
    chk("midrst_busy", 32'(bus.busy_o), 32'd0);
    chk("midrst_state", 32'(dut.state), 32'(IDLE));
    @(negedge PCLK);
    bus.ss_i  = 1'b1;
    PRESET    = 1'b0;
    pulse_cnt = 0;
    repeat (3) @(negedge PCLK);
    chk("postrst_pulses", 32'(pulse_cnt), 32'd0);
    run_vec(vecs[0], "postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
